// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-side hazard unit tracking EX/MEM/WB destination tags.
// Drives forwarding selects, stage enables, bubble insert and IF/ID flush.
// Ports: clk, reset (sync, active-low); id_ra/id_rb/id_rd + id_use_* read
//   fields; id_dest/id_rf_e/id_load of the ID instruction; branch_taken;
//   mem_req/mem_ready data-memory handshake. Outputs: pc_e, ifid_e,
//   ifid_flush, idex_e, exmem_e, memwb_e, cu_nop_sel, fwd_pa/pb/pd,
//   stall_count.
// Define HAZ_PERF_CNT_EN to build the saturating stall-cycle counter;
//   otherwise stall_count is tied to zero.
module hazard_sequencer #(
  parameter int STALL_CNT_W   = 16,
  parameter int NUM_REGS_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REGS_LOG2-1:0] id_ra,
  input  logic [NUM_REGS_LOG2-1:0] id_rb,
  input  logic [NUM_REGS_LOG2-1:0] id_rd,
  input  logic                     id_use_ra,
  input  logic                     id_use_rb,
  input  logic                     id_use_rd,
  input  logic [NUM_REGS_LOG2-1:0] id_dest,
  input  logic                     id_rf_e,
  input  logic                     id_load,
  input  logic                     branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     pc_e,
  output logic                     ifid_e,
  output logic                     ifid_flush,
  output logic                     idex_e,
  output logic                     exmem_e,
  output logic                     memwb_e,
  output logic                     cu_nop_sel,
  output logic [1:0]               fwd_pa,
  output logic [1:0]               fwd_pb,
  output logic [1:0]               fwd_pd,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  typedef logic [NUM_REGS_LOG2-1:0] reg_t;

  typedef struct packed {
    logic v;
    logic load;
    reg_t dest;
  } tag_t;

  // Highest register index is the PC; it is never forwarded.
  localparam reg_t PC_IDX = '1;

  tag_t ex_tag;
  tag_t mem_tag;
  tag_t wb_tag;

  logic mem_wait;
  logic ld_hit;
  logic load_use;

  function automatic logic [1:0] fwd_sel(
    input reg_t r,
    input logic u,
    input tag_t ex,
    input tag_t mem,
    input tag_t wb
  );
    logic [1:0] s;
    s = 2'b00;
    if (u && (r != PC_IDX)) begin
      // Load data is not ready in EX; fall through to older stages.
      if (ex.v && !ex.load && (ex.dest == r))
        s = 2'b01;
      else if (mem.v && (mem.dest == r))
        s = 2'b10;
      else if (wb.v && (wb.dest == r))
        s = 2'b11;
    end
    return s;
  endfunction

  assign mem_wait = mem_req & ~mem_ready;

  assign ld_hit = ex_tag.v & ex_tag.load &
    ((id_use_ra & (id_ra == ex_tag.dest)) |
     (id_use_rb & (id_rb == ex_tag.dest)) |
     (id_use_rd & (id_rd == ex_tag.dest)));

  assign load_use = ld_hit & ~mem_wait;

  always_comb begin
    pc_e       = 1'b1;
    ifid_e     = 1'b1;
    ifid_flush = 1'b0;
    idex_e     = 1'b1;
    exmem_e    = 1'b1;
    memwb_e    = 1'b1;
    cu_nop_sel = 1'b0;
    priority case (1'b1)
      !reset: begin
        cu_nop_sel = 1'b1;
      end
      mem_wait: begin
        pc_e    = 1'b0;
        ifid_e  = 1'b0;
        idex_e  = 1'b0;
        exmem_e = 1'b0;
        memwb_e = 1'b0;
      end
      load_use: begin
        pc_e       = 1'b0;
        ifid_e     = 1'b0;
        cu_nop_sel = 1'b1;
      end
      branch_taken: begin
        ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    fwd_pa = 2'b00;
    fwd_pb = 2'b00;
    fwd_pd = 2'b00;
    if (reset) begin
      fwd_pa = fwd_sel(id_ra, id_use_ra,
                       ex_tag, mem_tag, wb_tag);
      fwd_pb = fwd_sel(id_rb, id_use_rb,
                       ex_tag, mem_tag, wb_tag);
      fwd_pd = fwd_sel(id_rd, id_use_rd,
                       ex_tag, mem_tag, wb_tag);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_tag  <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else if (!mem_wait) begin
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
      if (load_use)
        ex_tag <= '0;
      else
        ex_tag <= tag_t'{v: id_rf_e,
                         load: id_load,
                         dest: id_dest};
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else if ((mem_wait | load_use) && (cnt_q != '1))
      cnt_q <= cnt_q + STALL_CNT_W'(1);
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed vector table plus randomized run
// against a queue-based pipeline model of hazard_sequencer.
module tb_hazard_sequencer;

  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] RUN = 7'b1101110;
  localparam logic [6:0] RST = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0001111;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] MW  = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] id_ra, id_rb, id_rd, id_dest;
  logic id_use_ra, id_use_rb, id_use_rd;
  logic id_rf_e, id_load, branch_taken;
  logic mem_req, mem_ready;
  logic pc_e, ifid_e, ifid_flush;
  logic idex_e, exmem_e, memwb_e, cu_nop_sel;
  logic [1:0] fwd_pa, fwd_pb, fwd_pd;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  hazard_sequencer #(
    .STALL_CNT_W(CW),
    .NUM_REGS_LOG2(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_ra(id_ra),
    .id_rb(id_rb),
    .id_rd(id_rd),
    .id_use_ra(id_use_ra),
    .id_use_rb(id_use_rb),
    .id_use_rd(id_use_rd),
    .id_dest(id_dest),
    .id_rf_e(id_rf_e),
    .id_load(id_load),
    .branch_taken(branch_taken),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .pc_e(pc_e),
    .ifid_e(ifid_e),
    .ifid_flush(ifid_flush),
    .idex_e(idex_e),
    .exmem_e(exmem_e),
    .memwb_e(memwb_e),
    .cu_nop_sel(cu_nop_sel),
    .fwd_pa(fwd_pa),
    .fwd_pb(fwd_pb),
    .fwd_pd(fwd_pd),
    .stall_count(stall_count)
  );

  typedef struct {
    logic rst;
    logic [3:0] ra, rb, rd;
    logic ura, urb, urd;
    logic [3:0] dest;
    logic rfe, ld, br, mreq, mrdy;
    logic [6:0] en;
    logic [1:0] fa, fb, fd;
    int st;
  } vec_t;

  typedef struct {
    logic v;
    logic ld;
    logic [3:0] d;
  } mt_t;

  // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  mt_t pipe[$];
  int mcnt;
  int npass = 0;
  int ntot = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst,
    input logic [3:0] ra, input logic ura,
    input logic [3:0] rb, input logic urb,
    input logic [3:0] rd, input logic urd,
    input logic [3:0] dest, input logic rfe, input logic ld,
    input logic br, input logic mreq, input logic mrdy,
    input logic [6:0] en,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [1:0] fd, input int st);
    vec_t v;
    v.rst = rst; v.ra = ra; v.ura = ura;
    v.rb = rb; v.urb = urb; v.rd = rd; v.urd = urd;
    v.dest = dest; v.rfe = rfe; v.ld = ld;
    v.br = br; v.mreq = mreq; v.mrdy = mrdy;
    v.en = en; v.fa = fa; v.fb = fb; v.fd = fd;
`ifdef HAZ_PERF_CNT_EN
    v.st = st;
`else
    v.st = (st < 0) ? -1 : 0;
`endif
    return v;
  endfunction

  function automatic bit m_lu(input vec_t v);
    mt_t e;
    e = pipe[0];
    if (v.mreq && !v.mrdy) return 0;
    if (!(e.v && e.ld)) return 0;
    return (v.ura && v.ra == e.d) ||
           (v.urb && v.rb == e.d) ||
           (v.urd && v.rd == e.d);
  endfunction

  function automatic logic [1:0] m_fwd(
    input logic [3:0] r, input logic u);
    if (!u || r == 4'd15) return 2'b00;
    for (int s = 0; s < 3; s++) begin
      if (pipe[s].v && pipe[s].d == r &&
          !(s == 0 && pipe[s].ld))
        return 2'(s + 1);
    end
    return 2'b00;
  endfunction

  function automatic vec_t m_exp(input vec_t vi);
    vec_t v;
    v = vi;
    v.fa = 2'b00; v.fb = 2'b00; v.fd = 2'b00;
    if (!v.rst) v.en = RST;
    else begin
      if (v.mreq && !v.mrdy) v.en = MW;
      else if (m_lu(v)) v.en = LU;
      else if (v.br) v.en = BR;
      else v.en = RUN;
      v.fa = m_fwd(v.ra, v.ura);
      v.fb = m_fwd(v.rb, v.urb);
      v.fd = m_fwd(v.rd, v.urd);
    end
`ifdef HAZ_PERF_CNT_EN
    v.st = mcnt;
`else
    v.st = 0;
`endif
    return v;
  endfunction

  task automatic m_step(input vec_t v);
    mt_t z, n;
    bit lu;
    z = '{v: 1'b0, ld: 1'b0, d: 4'd0};
    lu = m_lu(v);
    if (!v.rst) begin
      pipe = '{z, z, z};
      mcnt = 0;
    end else if (v.mreq && !v.mrdy) begin
      if (mcnt < CMAX) mcnt++;
    end else begin
      if (lu) begin
        if (mcnt < CMAX) mcnt++;
        pipe.push_front(z);
      end else begin
        n = '{v: v.rfe, ld: v.ld, d: v.dest};
        pipe.push_front(n);
      end
      void'(pipe.pop_back());
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    id_ra = v.ra; id_use_ra = v.ura;
    id_rb = v.rb; id_use_rb = v.urb;
    id_rd = v.rd; id_use_rd = v.urd;
    id_dest = v.dest; id_rf_e = v.rfe; id_load = v.ld;
    branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy;
  endtask

  task automatic check(input string nm, input int i,
                       input vec_t v);
    logic [12:0] act, exq;
    act = {pc_e, ifid_e, ifid_flush, idex_e, exmem_e,
           memwb_e, cu_nop_sel, fwd_pa, fwd_pb, fwd_pd};
    exq = {v.en, v.fa, v.fb, v.fd};
    ntot++;
    if (act === exq) npass++;
    else
      $display("FAIL %s[%0d] ctl/fwd got %b want %b",
               nm, i, act, exq);
    if (v.st >= 0) begin
      ntot++;
      if (stall_count === CW'(v.st)) npass++;
      else
        $display("FAIL %s[%0d] stall_count got %0d want %0d",
                 nm, i, stall_count, v.st);
    end
  endtask

  task automatic cycle(input string nm, input int i,
                       input vec_t v, input bit use_model);
    vec_t e;
    drive(v);
    @(negedge clk);
    e = use_model ? m_exp(v) : v;
    check(nm, i, e);
    @(posedge clk);
    m_step(v);
    #1;
  endtask

  initial begin
    vec_t r;
    mt_t z;
    z = '{v: 1'b0, ld: 1'b0, d: 4'd0};
    pipe = '{z, z, z};
    mcnt = 0;

    // rst ra u rb u rd u dst rfe ld br mrq mrdy | en fa fb fd st
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, RST,0,0,0,-1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, RST,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,3,1,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,3,1,0,0,0,0,0,0,0,0,0,0, RUN,1,0,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,0,0,0,0,0,0, RUN,0,2,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,0,0,0,0,0,0, RUN,0,3,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,0,0,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,5,1,1,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,0,0,5,1,0,0,0,0,0,0,0,0, LU,0,0,0,0));
    tbl.push_back(mk(1,0,0,5,1,0,0,0,0,0,0,0,0, RUN,0,2,0,1));
    tbl.push_back(mk(1,5,1,0,0,0,0,0,0,0,1,0,0, BR,3,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,7,1,0,0,0,0, RUN,0,0,0,1));
    tbl.push_back(mk(1,7,1,0,0,0,0,9,1,0,1,1,0, MW,1,0,0,1));
    tbl.push_back(mk(1,7,1,0,0,0,0,9,1,0,1,1,0, MW,1,0,0,2));
    tbl.push_back(mk(1,7,1,0,0,0,0,9,1,0,1,1,0, MW,1,0,0,3));
    tbl.push_back(mk(1,7,1,0,0,0,0,9,1,0,1,1,1, BR,1,0,0,4));
    tbl.push_back(mk(1,7,1,0,0,9,1,0,0,0,0,0,0, RUN,2,0,1,4));
    tbl.push_back(mk(1,7,1,0,0,0,0,0,0,0,0,1,0, MW,3,0,0,4));
    tbl.push_back(mk(0,7,1,0,0,0,0,0,0,0,0,1,0, RST,0,0,0,5));
    tbl.push_back(mk(1,7,1,0,0,9,1,15,1,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,15,1,15,1,0,0,0,0,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,15,1,0,0,0,0,2,1,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,2,0,2,1,0,0,2,1,0,0,0,0, RUN,0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,2,1,2,1,1,0,0,0, RUN,0,0,1,0));
    tbl.push_back(mk(1,2,0,2,0,2,0,0,0,0,0,0,0, RUN,0,0,0,0));
    tbl.push_back(mk(1,2,1,0,0,0,0,0,0,0,0,0,0, RUN,2,0,0,0));

    foreach (tbl[i]) cycle("vec", i, tbl[i], 1'b0);

    for (int i = 0; i < 1500; i++) begin
      r = tbl[0];
      r.rst  = ($urandom_range(0, 63) != 0);
      r.ra   = ($urandom_range(0, 7) == 0) ? 4'd15
               : 4'($urandom_range(0, 3));
      r.rb   = 4'($urandom_range(0, 3));
      r.rd   = 4'($urandom_range(0, 3));
      r.ura  = 1'($urandom);
      r.urb  = 1'($urandom);
      r.urd  = 1'($urandom);
      r.dest = ($urandom_range(0, 7) == 0) ? 4'd15
               : 4'($urandom_range(0, 3));
      r.rfe  = 1'($urandom);
      r.ld   = ($urandom_range(0, 2) == 0);
      r.br   = ($urandom_range(0, 5) == 0);
      r.mreq = ($urandom_range(0, 3) == 0);
      r.mrdy = 1'($urandom);
      cycle("rnd", i, r, 1'b1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
